// File: rtl/conv_acc_if.sv
// Handshake bundle between the CONV stream, conv_acc and the result consumer.
// The slave modport is the accumulator's view; master is the upstream/consumer side.
interface conv_acc_if #(
    parameter int LEN_LOG2 = 3,
    parameter int IN_W     = 13
);
    localparam int OUT_W = IN_W + LEN_LOG2;

    // Both ports follow the same valid/ready rule: a transfer happens on a rising
    // edge where valid and ready are both 1; a producer holds valid and data
    // stable until the transfer, and ready may change freely.
    logic             ACC_iClear;
    logic             ACC_iValid;
    logic [IN_W-1:0]  ACC_iData;
    logic             ACC_iReady;
    logic             ACC_oValid;
    logic [OUT_W-1:0] ACC_oData;
    logic             ACC_oReady;

    modport slave (
        input  ACC_iClear, ACC_iValid, ACC_iData, ACC_oReady,
        output ACC_iReady, ACC_oValid, ACC_oData
    );

    modport master (
        output ACC_iClear, ACC_iValid, ACC_iData, ACC_oReady,
        input  ACC_iReady, ACC_oValid, ACC_oData
    );
endinterface

// File: rtl/conv_acc.sv
// Windowed accumulator: sums 2**LEN_LOG2 CONV samples and holds the total until taken.
// Define ACC_AVG_EN to present the rounded-half-up window mean instead of the sum.
module conv_acc #(
    parameter int LEN_LOG2 = 3,
    parameter int IN_W     = 13
) (
    input  logic            clk,
    input  logic            reset,
    conv_acc_if.slave       acc,
    output logic            dbg_state
);
    localparam int OUT_W = IN_W + LEN_LOG2;
    localparam int CNT_W = LEN_LOG2 + 1;

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state;
    logic [OUT_W-1:0] sum;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last;
    logic [OUT_W-1:0] sum_next;
    logic [OUT_W-1:0] result;

    assign accept   = acc.ACC_iValid && acc.ACC_iReady;
    assign last     = (cnt == CNT_W'((2 ** LEN_LOG2) - 1));
    assign sum_next = sum + OUT_W'(acc.ACC_iData);

`ifdef ACC_AVG_EN
    // One extra bit keeps the rounding add from wrapping at full scale.
    logic [OUT_W:0] rounded;
    assign rounded = {1'b0, sum_next} + (OUT_W + 1)'(2 ** (LEN_LOG2 - 1));
    assign result  = OUT_W'(rounded >> LEN_LOG2);
`else
    assign result  = sum_next;
`endif

    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ACCUM;
            sum            <= '0;
            cnt            <= '0;
            acc.ACC_iReady <= 1'b0;
            acc.ACC_oValid <= 1'b0;
            acc.ACC_oData  <= '0;
        end else if (acc.ACC_iClear) begin
            state          <= ACCUM;
            sum            <= '0;
            cnt            <= '0;
            acc.ACC_iReady <= 1'b1;
            acc.ACC_oValid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    acc.ACC_iReady <= 1'b1;
                    if (accept) begin
                        if (last) begin
                            acc.ACC_oData  <= result;
                            acc.ACC_oValid <= 1'b1;
                            acc.ACC_iReady <= 1'b0;
                            sum            <= '0;
                            cnt            <= '0;
                            state          <= HOLD;
                        end else begin
                            sum <= sum_next;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // oValid is always 1 here, so oReady alone completes the transfer.
                    if (acc.ACC_oReady) begin
                        acc.ACC_oValid <= 1'b0;
                        acc.ACC_iReady <= 1'b1;
                        state          <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_acc.sv
// Self-checking bench for conv_acc: window sums (or means with ACC_AVG_EN),
// backpressure, clear and asynchronous reset behaviour.
module tb_conv_acc;
    localparam int LEN_LOG2 = 3;
    localparam int IN_W     = 13;
    localparam int OUT_W    = IN_W + LEN_LOG2;
    localparam int WIN      = 2 ** LEN_LOG2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dbg_state;
    always #5 clk = ~clk;

    conv_acc_if #(.LEN_LOG2(LEN_LOG2), .IN_W(IN_W)) acc ();

    conv_acc #(.LEN_LOG2(LEN_LOG2), .IN_W(IN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .acc       (acc.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [OUT_W-1:0] exp_q[$];
    int unsigned m_sum = 0;
    int unsigned m_cnt = 0;

    function automatic logic [OUT_W-1:0] expected_of(input int unsigned s);
`ifdef ACC_AVG_EN
        return OUT_W'((s + WIN / 2) >> LEN_LOG2);
`else
        return OUT_W'(s);
`endif
    endfunction

    task automatic model_accept(input logic [IN_W-1:0] d);
        m_sum += d;
        m_cnt++;
        if (m_cnt == WIN) begin
            exp_q.push_back(expected_of(m_sum));
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    // A result transfers on the next rising edge whenever both are high here.
    always @(negedge clk) begin
        if (!reset && acc.ACC_oValid && acc.ACC_oReady) begin
            if (exp_q.size() == 0) check("unexpected_out", acc.ACC_oData, 0);
            else check("result", acc.ACC_oData, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks (entered at posedge + 1) ----------------
    task automatic send(input logic [IN_W-1:0] d);
        int waited = 0;
        acc.ACC_iValid = 1'b1;
        acc.ACC_iData  = d;
        @(negedge clk);
        while (!acc.ACC_iReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!acc.ACC_iReady) begin
            check("send_timeout", 0, 1);
            acc.ACC_iValid = 1'b0;
            return;
        end
        model_accept(d);
        @(posedge clk); #1;
        acc.ACC_iValid = 1'b0;
        acc.ACC_iData  = 'x;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_window(input logic [IN_W-1:0] d);
        for (int i = 0; i < WIN; i++) send(d);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            idle(1);
            waited++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        time t0;
        acc.ACC_iClear = 1'b0;
        acc.ACC_iValid = 1'b0;
        acc.ACC_iData  = '0;
        acc.ACC_oReady = 1'b0;

        // Reset held 5 cycles, outputs must read 0 throughout.
        repeat (5) @(negedge clk);
        check("rst_iready", acc.ACC_iReady, 0);
        check("rst_ovalid", acc.ACC_oValid, 0);
        check("rst_odata",  acc.ACC_oData,  0);
        reset = 1'b0;
        #1 check("iready_before_edge", acc.ACC_iReady, 0);
        @(posedge clk); #1;
        check("iready_after_edge", acc.ACC_iReady, 1);

        // Steady stream of 5s, consumer always ready.
        acc.ACC_oReady = 1'b1;
        t0 = $time;
        send_window(13'd5);
        check("stream_cycles", 32'(($time - t0) / 10), WIN);
        @(negedge clk);
        check("pulse_ovalid", acc.ACC_oValid, 1);
        check("pulse_iready", acc.ACC_iReady, 0);
        @(negedge clk);
        check("pulse_ovalid_drop", acc.ACC_oValid, 0);
        check("pulse_iready_back", acc.ACC_iReady, 1);
        @(posedge clk); #1;

        // Ramp 1..WIN with random idle gaps.
        for (int i = 1; i <= WIN; i++) begin
            send(IN_W'(i));
            idle($urandom_range(0, 3));
        end
        drain();

        // Full scale, no wrap.
        send_window(13'd8191);
        drain();

        // Backpressure: result must stay put while valid input is refused.
        acc.ACC_oReady = 1'b0;
        send_window(13'd5);
        acc.ACC_iValid = 1'b1;
        acc.ACC_iData  = 13'd999;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ovalid", acc.ACC_oValid, 1);
            check("bp_odata",  acc.ACC_oData,  expected_of(5 * WIN));
            check("bp_iready", acc.ACC_iReady, 0);
        end
        @(posedge clk); #1;
        acc.ACC_iValid = 1'b0;
        acc.ACC_oReady = 1'b1;
        send_window(13'd2);
        drain();

        // Clear abandons a partial window; sample on the clear edge is dropped.
        for (int i = 0; i < 3; i++) send(13'd7);
        acc.ACC_iClear = 1'b1;
        acc.ACC_iValid = 1'b1;
        acc.ACC_iData  = 13'd100;
        @(posedge clk); #1;
        acc.ACC_iClear = 1'b0;
        acc.ACC_iValid = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        send_window(13'd2);
        drain();

        // Clear during HOLD discards the held result.
        acc.ACC_oReady = 1'b0;
        send_window(13'd1);
        @(negedge clk);
        check("hold_before_clear", acc.ACC_oValid, 1);
        @(posedge clk); #1;
        acc.ACC_iClear = 1'b1;
        @(posedge clk); #1;
        acc.ACC_iClear = 1'b0;
        void'(exp_q.pop_back());
        check("clr_hold_ovalid", acc.ACC_oValid, 0);
        check("clr_hold_iready", acc.ACC_iReady, 1);
        acc.ACC_oReady = 1'b1;
        send_window(13'd3);
        drain();

        // Asynchronous reset mid-window clears outputs immediately.
        for (int i = 0; i < 4; i++) send(13'd9);
        reset = 1'b1;
        #1;
        check("arst_odata",  acc.ACC_oData,  0);
        check("arst_ovalid", acc.ACC_oValid, 0);
        check("arst_iready", acc.ACC_iReady, 0);
        m_sum = 0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Random window after reset, with random consumer stalls.
        for (int i = 0; i < WIN; i++) begin
            acc.ACC_oReady = 1'($urandom_range(0, 1));
            send(IN_W'($urandom_range(0, 8191)));
        end
        acc.ACC_oReady = 1'b1;
        drain();
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/conv_acc.md
# conv_acc

Windowed accumulator that sits directly downstream of the CONV adder stage. It consumes the 13-bit unsigned CONV sum stream, adds up 2**LEN_LOG2 accepted samples, and presents the window total through a valid/ready output port. Each result is held until the consumer takes it. A synchronous clear abandons a partial window. It is the next stage in the Arifmetika datapath.

## Interface
- LEN_LOG2, 3, log2 of the window length (window = 2**LEN_LOG2 samples, range 1..8).
- IN_W, 13, input sample width; matches CONV output width.
- OUT_W (localparam), IN_W+LEN_LOG2, output width.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ACC_iClear  in  1  synchronous clear; abandons the current window or held result.
- ACC_iValid  in  1  input sample valid.
- ACC_iData  in  IN_W  unsigned input sample (CONV_oData).
- ACC_iReady  out  1  block accepts a sample this cycle; registered.
- ACC_oValid  out  1  window result valid; registered.
- ACC_oData  out  OUT_W  window result; registered.
- ACC_oReady  in  1  consumer accepts the result.

## Operation
- States: ACCUM (collecting samples) and HOLD (result presented). Reset state is ACCUM.
- Accept: ACC_iValid && ACC_iReady on a rising edge. The sum register adds the zero-extended ACC_iData, and the sample counter (LEN_LOG2+1 bits) increments.
- ACCUM -> HOLD: on the accept edge of sample 2**LEN_LOG2:
  - ACC_oData loads the final sum (including that sample).
  - ACC_oValid goes to 1; ACC_iReady goes to 0.
  - The sum register and counter return to 0.
- HOLD: ACC_iValid is ignored. ACC_oData and ACC_oValid stay stable until ACC_oReady=1.
- HOLD -> ACCUM: on the edge with ACC_oValid && ACC_oReady, ACC_oValid goes to 0 and ACC_iReady goes to 1.
- ACC_iClear=1 has priority over all other events on that edge:
  - Sum, counter and ACC_oValid go to 0; any held result is discarded.
  - ACC_iReady goes to 1; state goes to ACCUM.
  - A sample presented on the clear edge is dropped.
- Arithmetic: unsigned. OUT_W is exact, so there is no overflow and no wrap. Maximum is (2**IN_W-1)*2**LEN_LOG2.
- ACC_iData outside an accept is don't-care. X on ACC_iData must not reach state unless accepted.
- Reset mid-window or mid-HOLD: everything returns to reset values immediately; the partial window is lost.

## Timing
- Reset values: ACC_iReady=0, ACC_oValid=0, ACC_oData=0, sum=0, counter=0, state ACCUM.
- ACC_iReady rises on the first rising edge after reset deasserts.
- Latency: ACC_oValid is high in the cycle immediately after the edge that accepted the last sample of the window.
- Throughput: at most 2**LEN_LOG2 samples per 2**LEN_LOG2+1 cycles, because HOLD lasts at least one cycle.
- ACC_oReady held high gives a one-cycle ACC_oValid pulse per window.
- ACC_oReady may be high before ACC_oValid. It has no effect in ACCUM.

## Configuration
- ACC_AVG_EN defined: on the HOLD load, ACC_oData = (sum + 2**(LEN_LOG2-1)) >> LEN_LOG2, i.e. the mean rounded half-up.
  - The intermediate is OUT_W+1 bits wide, so there is no wrap.
  - Upper LEN_LOG2 bits of ACC_oData are 0.
- ACC_AVG_EN undefined: ACC_oData = the full window sum. No rounding logic is built.

## Test plan
- Reset: assert reset for 5 cycles, then release -> all outputs 0 while reset is high; ACC_iReady=1 one edge after release.
- Steady stream: 8 back-to-back samples of 5 (3+2 from CONV), ACC_oReady=1 -> ACC_oData=40 (ACC_AVG_EN: 5) with a one-cycle ACC_oValid pulse one cycle after the 8th accept; ACC_iReady=1 again the following edge.
- Ramp with gaps: samples 1..8 with 0-3 idle cycles of ACC_iValid=0 between them -> 36 (ACC_AVG_EN: 4.5 rounds to 5).
- Full scale: 8 samples of 8191 -> 65528 with no wrap (ACC_AVG_EN: 8191).
- Backpressure: ACC_oReady=0 for 10 cycles after a window of 5s, with ACC_iValid=1 throughout -> ACC_oData=40 and ACC_oValid=1 stay stable; ACC_iReady=0; no samples are absorbed. Then raise ACC_oReady -> the next window of 8×2 gives 16.
- Clear and reset mid-operation:
  - 3 samples of 7, then ACC_iClear, then 8 samples of 2 -> 16.
  - ACC_iClear during HOLD -> ACC_oValid drops next edge and the result is discarded.
  - Async reset after 4 samples -> outputs 0 immediately.
